// File: rtl/seq_mix_pkg.sv
// Shared types, default constants and helpers for the seq_mix_misr block.
package seq_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] DEFAULT_POLY = 8'h1D;
    localparam logic [7:0] DEFAULT_SEED = 8'h00;

    // Widest vector the rotate helper can handle; WIDTH must not exceed it.
    localparam int ROT_MAX_W = 64;

    // Rotate the low w bits of x left by n; bits at and above w come back zero.
    // Intended for constant w and n so it reduces to pure wiring.
    function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                  input int w,
                                                  input int n);
        logic [ROT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROT_MAX_W; i++) begin
            if (i < w) begin
                r[(i + n) % w] = x[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mix_stage.sv
// One registered nonlinear mixing stage of the seq_mix_misr pipeline.
module seq_mix_stage
    import seq_mix_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [ROT_MAX_W-1:0] x_ext;
    logic [WIDTH-1:0]     mix_d;

    // x' = x ^ (rotl1 & rotl2) ^ rotl(s+3), all rotations within WIDTH bits.
    always_comb begin
        x_ext = ROT_MAX_W'(in_data);
        mix_d = WIDTH'(x_ext
                       ^ (rotl(x_ext, WIDTH, 1) & rotl(x_ext, WIDTH, 2))
                       ^ rotl(x_ext, WIDTH, (STAGE + 3) % WIDTH));
    end

    // Valid bit travels with the data; bubbles simply carry valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // NOTE: datapath registers carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            out_data <= mix_d;
        end
    end

endmodule

// File: rtl/seq_mix_misr.sv
// Mixing pipeline followed by a MISR that compresses a run of num_vec vectors
// into an OUT_W-bit signature. Define SEQ_MIX_PARITY_EN to add the sig_par
// output (XOR of sig_out).
module seq_mix_misr
    import seq_mix_pkg::*;
#(
    parameter int               WIDTH  = 14,
    parameter int               OUT_W  = 8,
    parameter int               STAGES = 2,
    parameter logic [OUT_W-1:0] POLY   = OUT_W'(DEFAULT_POLY),
    parameter logic [OUT_W-1:0] SEED   = OUT_W'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_vec,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] sig_out
`ifdef SEQ_MIX_PARITY_EN
    ,
    output logic             sig_par
`endif
);

    state_t             state, state_d;
    logic [15:0]        num_q;
    logic [15:0]        acc_cnt;
    logic [3:0]         drain_cnt;
    logic [OUT_W-1:0]   misr, misr_d;
    logic [OUT_W-1:0]   fold;
    logic               xfer;
    logic               start_ok;
    logic [STAGES:0]    pipe_valid;
    logic [WIDTH-1:0]   pipe_data [0:STAGES];

    // Handshake and status outputs, forced low while reset is applied.
    assign in_ready = !rst && (state == ST_RUN) && (acc_cnt < num_q);
    assign busy     = !rst && (state == ST_RUN || state == ST_DRAIN);
    assign done     = !rst && (state == ST_DONE);
    assign xfer     = in_valid && in_ready;
    assign start_ok = (state == ST_IDLE) && start;

    assign pipe_valid[0] = xfer;
    assign pipe_data[0]  = in_data;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        seq_mix_stage #(
            .WIDTH (WIDTH),
            .STAGE (s)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (pipe_valid[s]),
            .in_data   (pipe_data[s]),
            .out_valid (pipe_valid[s+1]),
            .out_data  (pipe_data[s+1])
        );
    end

    // Next-state logic for the run controller.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state;
        case (state)
            ST_IDLE:  if (start) state_d = (num_vec == 16'd0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (xfer && (acc_cnt == num_q - 16'd1)) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == 4'(STAGES - 1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register plus the accepted-vector and drain counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state     <= ST_IDLE;
            num_q     <= '0;
            acc_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_d;
            if (start_ok) begin
                num_q   <= num_vec;
                acc_cnt <= '0;
            end else if (xfer) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 4'd1 : 4'd0;
        end
    end

    // Fold the pipeline output onto OUT_W bits: bit i lands on i mod OUT_W.
    always_comb begin
        fold = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fold[i % OUT_W] = fold[i % OUT_W] ^ pipe_data[STAGES][i];
        end
    end

    // MISR next value: seed on an accepted start, shift-and-fold on a valid output.
    always_comb begin
        misr_d = misr;
        if (start_ok) begin
            misr_d = SEED;
        end else if (pipe_valid[STAGES]) begin
            misr_d = {misr[OUT_W-2:0], 1'b0} ^ (misr[OUT_W-1] ? POLY : '0) ^ fold;
        end
    end

    // MISR register.
    always_ff @(posedge clk) begin
        if (rst) begin
            misr <= SEED;
        end else begin
            misr <= misr_d;
        end
    end

    // Capture the final signature as DONE is entered so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_out <= '0;
        end else if (state != ST_DONE && state_d == ST_DONE) begin
            sig_out <= misr_d;
        end
    end

`ifdef SEQ_MIX_PARITY_EN
    // Parity of the signature, tracking sig_out load-for-load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_par <= 1'b0;
        end else if (state != ST_DONE && state_d == ST_DONE) begin
            sig_par <= ^misr_d;
        end
    end
`endif

endmodule
